// File: rtl/ws2812_pkg.sv
// Shared types and timing defaults for the WS2812 GRB serial transmitter.
// Defaults assume a 50 MHz clk.
package ws2812_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } ws2812_state_e;

    localparam int BITS_PER_LED = 24;

    localparam int DEF_NUM_LEDS = 5;
    localparam int DEF_T0H      = 20;
    localparam int DEF_T1H      = 40;
    localparam int DEF_TBIT     = 63;
    localparam int DEF_TRESET   = 3000;

    function automatic int frame_width(input int num_leds);
        return BITS_PER_LED * num_leds;
    endfunction

    // One width covers both the per-bit timer and the latch counter.
    function automatic int timer_width(input int tbit, input int treset);
        return $clog2((tbit > treset) ? tbit : treset);
    endfunction

endpackage

// File: rtl/ws2812_tx_if.sv
// Frame request / status bundle between a pattern generator (master) and
// the WS2812 transmitter (slave).
interface ws2812_tx_if #(
    parameter int NUM_LEDS = ws2812_pkg::DEF_NUM_LEDS
);
    import ws2812_pkg::*;

    // Handshake: the master holds GRBSeq and raises Go; the request is taken
    // on the first clk edge where Go=1 and Busy=0 (idle). Go seen while Busy=1
    // is dropped, never queued. Done pulses one cycle when the latch gap ends.
    logic [frame_width(NUM_LEDS)-1:0] GRBSeq;
    logic                             Go;
    logic                             Dout;
    logic                             Busy;
    logic                             Done;
    ws2812_state_e                    dbg_state;

    modport master (
        output GRBSeq,
        output Go,
        input  Dout,
        input  Busy,
        input  Done,
        input  dbg_state
    );

    modport slave (
        input  GRBSeq,
        input  Go,
        output Dout,
        output Busy,
        output Done,
        output dbg_state
    );

endinterface

// File: rtl/ws2812_bit_timer.sv
// Per-bit NRZ pulse timer: counts 0..TBIT-1 while enabled and produces the
// registered line level for the bit value presented for the coming cycle.
module ws2812_bit_timer #(
    parameter int T0H   = ws2812_pkg::DEF_T0H,
    parameter int T1H   = ws2812_pkg::DEF_T1H,
    parameter int TBIT  = ws2812_pkg::DEF_TBIT,
    parameter int CNT_W = $clog2(TBIT)
) (
    input  logic clk,
    input  logic reset,
    input  logic bit_i,
    input  logic en_i,
    output logic level_o,
    output logic eob_o
);

    localparam logic [CNT_W-1:0] T0H_C   = CNT_W'(T0H);
    localparam logic [CNT_W-1:0] T1H_C   = CNT_W'(T1H);
    localparam logic [CNT_W-1:0] TLAST_C = CNT_W'(TBIT - 1);

    logic [CNT_W-1:0] t_q, t_d;
    logic             run_q;
    logic             level_q, level_d;

    // en_i and bit_i describe the next cycle, so level_q lines up with it.
    // A timer that was idle restarts at t=0, which clears it on every start.
    always_comb begin
        t_d     = '0;
        level_d = 1'b0;
        if (en_i) begin
            if (run_q && (t_q != TLAST_C)) begin
                t_d = t_q + 1'b1;
            end
            level_d = (t_d < (bit_i ? T1H_C : T0H_C));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            t_q     <= '0;
            run_q   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            t_q     <= t_d;
            run_q   <= en_i;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;
    assign eob_o   = run_q && (t_q == TLAST_C);

endmodule

// File: rtl/ws2812_tx.sv
// WS2812 GRB frame transmitter: shifts 24*NUM_LEDS bits MSB first, then holds
// the line low for the latch gap. Define WS2812_TX_AUTO_EN to free-run frames.
module ws2812_tx
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS = DEF_NUM_LEDS,
    parameter int T0H      = DEF_T0H,
    parameter int T1H      = DEF_T1H,
    parameter int TBIT     = DEF_TBIT,
    parameter int TRESET   = DEF_TRESET
) (
    input logic        clk,
    input logic        reset,
    ws2812_tx_if.slave bus
);

    localparam int FW    = frame_width(NUM_LEDS);
    localparam int BC_W  = $clog2(FW + 1);
    localparam int TMR_W = timer_width(TBIT, TRESET);

    localparam logic [BC_W-1:0]  FW_C    = BC_W'(FW);
    localparam logic [BC_W-1:0]  ONE_C   = BC_W'(1);
    localparam logic [TMR_W-1:0] RLAST_C = TMR_W'(TRESET - 1);

    ws2812_state_e    state_q, state_d;
    logic [FW-1:0]    shift_q, shift_d;
    logic [BC_W-1:0]  bitcnt_q, bitcnt_d;
    logic [TMR_W-1:0] latch_q, latch_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic timer_en;
    logic bit_eob;
    logic bit_level;

    // All registered outputs are computed from next-state values so they
    // line up with the state they describe.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        latch_d  = '0;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.Go) begin
                    state_d  = SEND;
                    shift_d  = bus.GRBSeq;
                    bitcnt_d = FW_C;
                end
            end
            SEND: begin
                if (bit_eob) begin
                    shift_d  = {shift_q[FW-2:0], 1'b0};
                    bitcnt_d = bitcnt_q - 1'b1;
                    if (bitcnt_q == ONE_C) begin
                        state_d = LATCH;
                    end
                end
            end
            LATCH: begin
                if (latch_q == RLAST_C) begin
                    done_d = 1'b1;
`ifdef WS2812_TX_AUTO_EN
                    state_d  = SEND;
                    shift_d  = bus.GRBSeq;
                    bitcnt_d = FW_C;
`else
                    state_d  = IDLE;
`endif
                end else begin
                    latch_d = latch_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bitcnt_q <= '0;
            latch_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            latch_q  <= latch_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign timer_en = (state_d == SEND);

    ws2812_bit_timer #(
        .T0H   (T0H),
        .T1H   (T1H),
        .TBIT  (TBIT),
        .CNT_W (TMR_W)
    ) u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .bit_i   (shift_d[FW-1]),
        .en_i    (timer_en),
        .level_o (bit_level),
        .eob_o   (bit_eob)
    );

    assign bus.Dout      = bit_level;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_ws2812_tx.sv
// Directed bench for ws2812_tx at default timing (5 LEDs, 63-cycle bits,
// 3000-cycle latch); frame waveforms are recorded per bit and checked inline.
module tb_ws2812_tx;
    import ws2812_pkg::*;

    localparam int FW      = 120;
    localparam int TBIT_C  = 63;
    localparam int BITS_C  = 7560;
    localparam int FRAME_C = 10560;

    localparam logic [FW-1:0] P_MSB = 120'h800000_000000_000000_000000_000000;
    localparam logic [FW-1:0] P1    = 120'hA5C30F_1E2D3C_4B5A69_788796_A5B4C3;
    localparam logic [FW-1:0] P2    = 120'h123456_789ABC_DEF012_345678_9ABCDE;
    localparam logic [FW-1:0] P3    = 120'h00FF00_F0F0F0_AAAAAA_555555_0F0F0F;
    localparam logic [FW-1:0] P4    = 120'hC0FFEE_BADA55_0DDBA1_F00D42_7E57ED;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ws2812_tx_if #(.NUM_LEDS(5)) bus ();

    ws2812_tx #(
        .NUM_LEDS (5),
        .T0H      (20),
        .T1H      (40),
        .TBIT     (63),
        .TRESET   (3000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    int   hi_cnt    [FW];
    int   first_low [FW];
    int   busy_low;
    int   latch_high;
    int   done_early;
    int   done_at;
    logic busy_at_done;
    logic dout_at_done;
    logic last_dout, last_busy, last_done;

    task automatic go_pulse();
        @(posedge clk);
        #1 bus.Go = 1'b1;
        @(posedge clk);
        #1 bus.Go = 1'b0;
    endtask

    // Records one frame starting at its first output cycle (c=0). With
    // reuse_first the c=0 sample is the previous frame's Done-cycle sample.
    task automatic capture_frame(input bit reuse_first, input int go_c1, input int go_c2,
                                 input int chg_c, input logic [FW-1:0] chg_val);
        logic d, b, dn;
        busy_low     = 0;
        latch_high   = 0;
        done_early   = 0;
        done_at      = -1;
        busy_at_done = 1'bx;
        dout_at_done = 1'bx;
        for (int i = 0; i < FW; i++) begin
            hi_cnt[i]    = 0;
            first_low[i] = TBIT_C;
        end
        for (int c = 0; c < FRAME_C + 20; c++) begin
            if (c == 0 && reuse_first) begin
                d  = last_dout;
                b  = last_busy;
                dn = last_done;
            end else begin
                @(negedge clk);
                d  = bus.Dout;
                b  = bus.Busy;
                dn = bus.Done;
            end
            if (c == go_c1 || c == go_c2) bus.Go = 1'b1;
            else if ((go_c1 >= 0 && c == go_c1 + 1) || (go_c2 >= 0 && c == go_c2 + 1)) bus.Go = 1'b0;
            if (c == chg_c) bus.GRBSeq = chg_val;
            if (c < BITS_C) begin
                if (d === 1'b1) hi_cnt[c / TBIT_C]++;
                else if (first_low[c / TBIT_C] == TBIT_C) first_low[c / TBIT_C] = c % TBIT_C;
            end else if (c < FRAME_C && d !== 1'b0) begin
                latch_high++;
            end
            if (c < FRAME_C && b !== 1'b1) busy_low++;
            if (c >= 1 && c < FRAME_C && dn !== 1'b0) done_early++;
            if (c >= FRAME_C && dn === 1'b1) begin
                done_at      = c;
                busy_at_done = b;
                dout_at_done = d;
                last_dout    = d;
                last_busy    = b;
                last_done    = dn;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        bus.Go     = 1'b1;
        bus.GRBSeq = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.Dout !== 1'b0) begin failures++; $display("FAIL reset_dout: got %b want 0", bus.Dout); end
        checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.Busy); end
        checks++; if (bus.Done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", bus.Done); end
        checks++; if (bus.dbg_state !== IDLE) begin failures++; $display("FAIL reset_state: got %0d want %0d", bus.dbg_state, IDLE); end
        bus.Go = 1'b0;
        reset  = 1'b0;
        @(negedge clk);
        checks++; if (bus.Busy !== 1'b0 || bus.dbg_state !== IDLE) begin failures++; $display("FAIL idle_after_reset: busy=%b state=%0d want 0/%0d", bus.Busy, bus.dbg_state, IDLE); end
    endtask

    task automatic test_single_msb();
        logic [FW-1:0] data;
        int exp_hi;
        data       = P_MSB;
        bus.GRBSeq = data;
        go_pulse();
        capture_frame(1'b0, -1, -1, -1, '0);
        for (int i = 0; i < FW; i++) begin
            exp_hi = data[FW-1-i] ? 40 : 20;
            checks++;
            if (hi_cnt[i] !== exp_hi || first_low[i] !== exp_hi) begin
                failures++; $display("FAIL msb_bit%0d: high=%0d first_low=%0d want %0d", i, hi_cnt[i], first_low[i], exp_hi);
            end
        end
        checks++; if (busy_low !== 0) begin failures++; $display("FAIL msb_busy_low: got %0d cycles want 0", busy_low); end
        checks++; if (latch_high !== 0) begin failures++; $display("FAIL msb_latch_high: got %0d cycles want 0", latch_high); end
        checks++; if (done_early !== 0) begin failures++; $display("FAIL msb_done_early: got %0d want 0", done_early); end
        checks++; if (done_at !== FRAME_C) begin failures++; $display("FAIL msb_done_at: got %0d want %0d", done_at, FRAME_C); end
        checks++; if (busy_at_done !== 1'b0) begin failures++; $display("FAIL msb_busy_at_done: got %b want 0", busy_at_done); end
        checks++; if (dout_at_done !== 1'b0) begin failures++; $display("FAIL msb_dout_at_done: got %b want 0", dout_at_done); end
        @(negedge clk);
        checks++; if (bus.Done !== 1'b0) begin failures++; $display("FAIL msb_done_width: got %b want 0", bus.Done); end
    endtask

    task automatic test_ignore_go();
        logic [FW-1:0] data;
        int exp_hi;
        int busy_seen;
        int done_seen;
        data       = P1;
        bus.GRBSeq = data;
        go_pulse();
        capture_frame(1'b0, 30 * 63 + 7, 8000, 100, P2);
        for (int i = 0; i < FW; i++) begin
            exp_hi = data[FW-1-i] ? 40 : 20;
            checks++;
            if (hi_cnt[i] !== exp_hi || first_low[i] !== exp_hi) begin
                failures++; $display("FAIL ign_bit%0d: high=%0d first_low=%0d want %0d", i, hi_cnt[i], first_low[i], exp_hi);
            end
        end
        checks++; if (done_early !== 0) begin failures++; $display("FAIL ign_done_early: got %0d want 0", done_early); end
        checks++; if (done_at !== FRAME_C) begin failures++; $display("FAIL ign_done_at: got %0d want %0d", done_at, FRAME_C); end
        busy_seen = 0;
        done_seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (bus.Busy !== 1'b0) busy_seen++;
            if (bus.Done !== 1'b0) done_seen++;
        end
        checks++; if (busy_seen !== 0) begin failures++; $display("FAIL ign_queued_busy: got %0d cycles want 0", busy_seen); end
        checks++; if (done_seen !== 0) begin failures++; $display("FAIL ign_extra_done: got %0d want 0", done_seen); end
    endtask

    task automatic test_back_to_back();
        logic [FW-1:0] data;
        int exp_hi;
        data       = '1;
        bus.GRBSeq = data;
        @(posedge clk);
        #1 bus.Go = 1'b1;
        @(posedge clk);
        #1;
        capture_frame(1'b0, -1, -1, 5000, P2);
        for (int i = 0; i < FW; i++) begin
            checks++;
            if (hi_cnt[i] !== 40 || first_low[i] !== 40) begin
                failures++; $display("FAIL ones_bit%0d: high=%0d first_low=%0d want 40", i, hi_cnt[i], first_low[i]);
            end
        end
        checks++; if (busy_low !== 0) begin failures++; $display("FAIL ones_busy_low: got %0d cycles want 0", busy_low); end
        checks++; if (latch_high !== 0) begin failures++; $display("FAIL ones_latch_high: got %0d cycles want 0", latch_high); end
        checks++; if (done_at !== FRAME_C) begin failures++; $display("FAIL ones_done_at: got %0d want %0d", done_at, FRAME_C); end
        checks++; if (busy_at_done !== 1'b0) begin failures++; $display("FAIL ones_busy_at_done: got %b want 0", busy_at_done); end
        @(posedge clk);
        #1 bus.Go = 1'b0;
        data = P2;
        capture_frame(1'b0, -1, -1, -1, '0);
        for (int i = 0; i < FW; i++) begin
            exp_hi = data[FW-1-i] ? 40 : 20;
            checks++;
            if (hi_cnt[i] !== exp_hi || first_low[i] !== exp_hi) begin
                failures++; $display("FAIL b2b_bit%0d: high=%0d first_low=%0d want %0d", i, hi_cnt[i], first_low[i], exp_hi);
            end
        end
        checks++; if (busy_low !== 0) begin failures++; $display("FAIL b2b_busy_low: got %0d cycles want 0", busy_low); end
        checks++; if (done_at !== FRAME_C) begin failures++; $display("FAIL b2b_done_at: got %0d want %0d", done_at, FRAME_C); end
    endtask

    task automatic test_reset_mid();
        logic [FW-1:0] data;
        int exp_hi;
        int done_seen;
        bus.GRBSeq = P3;
        go_pulse();
        repeat (50 * 63 + 11) @(negedge clk);
        checks++; if (bus.Dout !== 1'b1 || bus.Busy !== 1'b1) begin failures++; $display("FAIL mid_pre_reset: dout=%b busy=%b want 1/1", bus.Dout, bus.Busy); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.Dout !== 1'b0) begin failures++; $display("FAIL mid_reset_dout: got %b want 0", bus.Dout); end
        checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy: got %b want 0", bus.Busy); end
        checks++; if (bus.dbg_state !== IDLE) begin failures++; $display("FAIL mid_reset_state: got %0d want %0d", bus.dbg_state, IDLE); end
        reset      = 1'b0;
        data       = P4;
        bus.GRBSeq = data;
        done_seen  = (bus.Done !== 1'b0) ? 1 : 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.Done !== 1'b0) done_seen++;
        end
        checks++; if (done_seen !== 0) begin failures++; $display("FAIL mid_reset_done: got %0d pulses want 0", done_seen); end
        go_pulse();
        capture_frame(1'b0, -1, -1, -1, '0);
        for (int i = 0; i < FW; i++) begin
            exp_hi = data[FW-1-i] ? 40 : 20;
            checks++;
            if (hi_cnt[i] !== exp_hi || first_low[i] !== exp_hi) begin
                failures++; $display("FAIL mid_new_bit%0d: high=%0d first_low=%0d want %0d", i, hi_cnt[i], first_low[i], exp_hi);
            end
        end
        checks++; if (done_at !== FRAME_C) begin failures++; $display("FAIL mid_new_done_at: got %0d want %0d", done_at, FRAME_C); end
    endtask

    task automatic test_auto();
        logic [FW-1:0] pats [3];
        logic [FW-1:0] data;
        int exp_hi;
        pats[0]    = P1;
        pats[1]    = P2;
        pats[2]    = P3;
        bus.GRBSeq = pats[0];
        go_pulse();
        for (int f = 0; f < 3; f++) begin
            capture_frame(f != 0, -1, -1, (f < 2) ? 100 : -1, pats[(f < 2) ? f + 1 : 2]);
            data = pats[f];
            for (int i = 0; i < FW; i++) begin
                exp_hi = data[FW-1-i] ? 40 : 20;
                checks++;
                if (hi_cnt[i] !== exp_hi || first_low[i] !== exp_hi) begin
                    failures++; $display("FAIL auto%0d_bit%0d: high=%0d first_low=%0d want %0d", f, i, hi_cnt[i], first_low[i], exp_hi);
                end
            end
            checks++; if (busy_low !== 0) begin failures++; $display("FAIL auto%0d_busy_low: got %0d want 0", f, busy_low); end
            checks++; if (done_early !== 0) begin failures++; $display("FAIL auto%0d_done_early: got %0d want 0", f, done_early); end
            checks++; if (done_at !== FRAME_C) begin failures++; $display("FAIL auto%0d_done_at: got %0d want %0d", f, done_at, FRAME_C); end
            checks++; if (busy_at_done !== 1'b1 || dout_at_done !== 1'b1) begin failures++; $display("FAIL auto%0d_done_cycle: busy=%b dout=%b want 1/1", f, busy_at_done, dout_at_done); end
        end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.Busy !== 1'b0 || bus.dbg_state !== IDLE) begin failures++; $display("FAIL auto_reset: busy=%b state=%0d want 0/%0d", bus.Busy, bus.dbg_state, IDLE); end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
`ifdef WS2812_TX_AUTO_EN
        test_auto();
`else
        test_single_msb();
        test_ignore_go();
        test_back_to_back();
        test_reset_mid();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ws2812_tx.md
Name: ws2812_tx

Overview:
- Serial transmitter for WS2812-class GRB LED strings.
- Consumes the 24-bit-per-LED GRB frame produced by the pattern generators, such as the cylon sequencers.
- Emits the single-wire NRZ pulse-width waveform, followed by the latch (reset) low period.
- Sits between the pattern FSM and the strip's DIN pin; one frame is sent per Go request.

Parameters:
- NUM_LEDS, 5: LEDs per frame; frame width is 24*NUM_LEDS bits.
- T0H, 20: clk cycles Dout is high for a 0 bit (0.4 us at 50 MHz).
- T1H, 40: clk cycles Dout is high for a 1 bit (0.8 us).
- TBIT, 63: total clk cycles per bit (1.26 us); TBIT > T1H > T0H > 0.
- TRESET, 3000: clk cycles Dout is held low after the last bit (60 us latch).

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- GRBSeq  in  24*NUM_LEDS  frame data. Bits [24*NUM_LEDS-1 -: 24] are LED0, the first LED on the wire. Each LED is ordered G[7:0],R[7:0],B[7:0], MSB first.
- Go  in  1  frame request; sampled only in IDLE.
- Dout  out  1  registered serial data to strip.
- Busy  out  1  high while a frame or latch period is in progress.
- Done  out  1  one-cycle pulse when the latch period completes.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, Dout=0, Busy=0, Done=0, shift register=0, all counters=0. Reset mid-frame aborts immediately; Dout=0 on the next edge; no Done is issued.
- States are IDLE, SEND, LATCH.
- IDLE:
  - Dout=0, Busy=0.
  - Go=1 at edge k: latch GRBSeq into shift register, clear bit timer, load bit counter with 24*NUM_LEDS, go to SEND.
  - At k+1, Busy=1 and Dout=1 (first high cycle of bit 24*NUM_LEDS-1).
- SEND:
  - Bit timer t counts 0..TBIT-1.
  - Dout=1 while t < (current MSB ? T1H : T0H), else Dout=0.
  - At t=TBIT-1: shift left by 1, decrement bit counter, reset t.
  - When the last bit's t=TBIT-1 completes, go to LATCH.
  - No gap between bits; GRBSeq changes during SEND are ignored.
- LATCH:
  - Dout=0; counter runs TRESET cycles.
  - On the final cycle, go to IDLE and assert Done=1 for exactly the first IDLE cycle; Busy=0 in that same cycle.
- Timing: from the first Dout-high cycle to the Done cycle is exactly 24*NUM_LEDS*TBIT + TRESET cycles (10560 at defaults).
- Go in the Done cycle is accepted as a new request (back-to-back frames).
- Go while Busy=1 is ignored and not queued.
- Counter widths: bit counter $clog2(24*NUM_LEDS+1); timer $clog2(max(TBIT,TRESET)). No wrap-around is possible within legal parameters.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro WS2812_TX_AUTO_EN.
- When defined:
  - After LATCH, the block re-samples GRBSeq and goes straight to SEND without waiting for Go, so it free-runs after the first Go.
  - Busy stays 1 continuously, including the Done cycle.
  - Done still pulses once per frame.
  - Only reset returns the block to IDLE.
- When undefined: behaviour is exactly as above.
- Port list is identical in both builds.

Decomposition:
- Package ws2812_pkg holds:
  - the state enum (IDLE, SEND, LATCH);
  - the bits-per-LED constant (24);
  - default timing constants for a 50 MHz clk;
  - a helper function computing frame width.
- One sub-module, ws2812_bit_timer:
  - inputs: clk, reset, bit value, enable;
  - outputs: the bit's Dout level and an end-of-bit strobe;
  - it contains the T0H/T1H/TBIT counter.
- ws2812_tx keeps the FSM, shift register, bit counter and latch counter.

Test Plan:
- Reset, then Go with GRBSeq=120'h800000_000000_000000_000000_000000:
  - bit 0 gives Dout high 40 / low 23;
  - bits 1..119 each give high 20 / low 43;
  - then 3000 low;
  - Done at cycle 10560 after the first high.
- GRBSeq=all-ones: 120 consecutive pulses of high 40 / low 23; Busy stays 1 throughout; Dout never high during LATCH.
- Go pulsed again at bit 30 and during LATCH: ignored, exactly one Done; change GRBSeq mid-frame and confirm the waveform reflects the sampled value.
- Go held high through the Done cycle: second frame starts on the next cycle with no Busy gap beyond the single Done cycle.
- Reset asserted during bit 50:
  - next cycle Dout=0, Busy=0, Done stays 0;
  - new Go sends the new GRBSeq from bit 119.
- With WS2812_TX_AUTO_EN: single Go followed by three consecutive frames, each 10560 cycles apart; Done pulses three times; Busy never drops.
